pipelined_cla_adder: RTL and testbench
======================================

# pipelined_cla_adder

Parametrised, pipelined successor to the team's 64-bit carry-lookahead adder. It splits a WIDTH-bit add/subtract into STAGES carry-lookahead slices, one slice per pipeline stage, with registered inter-slice carries. A valid/ready handshake on both sides supports backpressure. It sits between the operand-issue logic and the writeback/result path, and replaces the combinational adder wherever the 64-bit carry chain misses timing.

## Interface
- WIDTH, 64: operand/result width; must be a multiple of STAGES.
- STAGES, 4: pipeline depth = number of slices; slice width SW = WIDTH/STAGES; STAGES=1 is legal (single registered adder).
- BLOCK, 4: CLA group width inside a slice; SW must be a multiple of BLOCK.
- CLK  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat this cycle.
- in_a  input  WIDTH  operand A (unsigned or two's complement).
- in_b  input  WIDTH  operand B.
- cin  input  1  carry in (add mode only).
- sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1; cin ignored).
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts result this cycle.
- sum  output  WIDTH  result modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1 (in sub mode, 1 = no borrow).
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Accept: a beat is taken on a rising edge where in_valid && in_ready.
- in_ready = out_ready || !out_valid (combinational). Stall = out_valid && !out_ready; on stall every pipeline register holds.
- Stage 0 stores the effective B (in_b, or ~in_b when sub), the effective carry (cin, or 1 when sub), and the raw operands. Slice s (bits s*SW .. s*SW+SW-1) is added in stage s using a BLOCK-grouped CLA, with the carry from slice s-1 taken from a register.
- Operand skew: slice s operands are delayed s stages. Result de-skew: slice s result is delayed STAGES-1-s stages, so all slices emerge together.
- Each stage has a valid bit. Bubbles propagate; they are not collapsed. A non-stalled cycle advances all stages, including invalid ones.
- cout and overflow come from the last slice. overflow uses that slice's internal carry into bit WIDTH-1.
- Results leave in acceptance order. No reordering, no drops, no duplicates.
- When out_valid=0, the values on sum/cout/overflow are don't-care; a bench must check them only when out_valid=1.

## Timing
- Latency: a beat accepted at edge k appears with out_valid=1 after edge k+STAGES, provided no stall occurs in between. Each stall cycle adds exactly 1 cycle.
- Throughput: 1 beat/cycle while out_ready=1.
- Under stall, out_valid/sum/cout/overflow stay stable until the edge where out_ready=1.
- reset=0, at any time and asynchronously: all valid bits clear, all data registers clear.
  - Reset values: out_valid=0, sum=0, cout=0, overflow=0, in_ready=1.
  - In-flight beats are discarded.
- First edge after reset deasserts (goes to 1): a beat may be accepted. Deassertion is assumed synchronous to CLK by the system.
- Simultaneous accept and output hand-off on the same edge (full pipeline, out_ready=1): both occur; no bubble is inserted.
- Wrap-around: sum wraps modulo 2^WIDTH, and cout reports the lost carry.

## Test plan
- Reset/idle: hold reset=0 for 3 cycles, then release. Required: out_valid=0, sum=0, cout=0, overflow=0, in_ready=1. No out_valid for 10 idle cycles.
- Latency/carry chain (WIDTH=64, STAGES=4): A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1, sub=0. Required: out_valid exactly 4 cycles later, sum=0, cout=1, overflow=0.
- Subtract/overflow: A=0x8000_0000_0000_0000, B=1, sub=1. Required: sum=0x7FFF_FFFF_FFFF_FFFF, cout=1, overflow=1. Then A=0, B=1, sub=1. Required: sum=0xFFFF_FFFF_FFFF_FFFF, cout=0, overflow=0.
- Streaming: 200 back-to-back random beats with out_ready=1. Required: 200 results in order, each equal to the 65-bit reference A+B+cin (or A-B), zero bubbles after the first 4 cycles.
- Backpressure: random out_ready (~50% duty) and random in_valid over 500 beats. Required:
  - no loss, duplication or reordering;
  - outputs stable while stalled;
  - in_ready=0 exactly when out_valid=1 and out_ready=0.
- Reset mid-operation: fill the pipeline with 4 beats, pulse reset=0 mid-cycle. Required: out_valid drops immediately, the 4 beats never appear, and the next accepted beat returns after 4 cycles.
- Parameter sweep: repeat the streaming test at (WIDTH,STAGES,BLOCK) = (32,1,4), (64,2,8), (128,8,4). Required: all results correct, latency = STAGES.

Source files
------------

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// master drives operands and out_ready; slave is the adder itself.
interface pipelined_cla_adder_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, in_a, in_b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, in_a, in_b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// WIDTH-bit add/subtract split into STAGES carry-lookahead slices, one slice per
// pipeline stage, with registered inter-slice carries and valid/ready backpressure.
module pipelined_cla_adder #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned STAGES = 4,
    parameter int unsigned BLOCK  = 4
) (
    input  logic                 CLK,
    input  logic                 reset,
    pipelined_cla_adder_if.slave bus
);
    localparam int unsigned SW = WIDTH / STAGES;
    localparam int unsigned NB = SW / BLOCK;

    if (((WIDTH % STAGES) != 0) || ((SW % BLOCK) != 0) || (STAGES == 0)) begin : g_bad_params
        $error("pipelined_cla_adder: WIDTH must split into STAGES slices of whole BLOCK groups");
    end

    logic              stall_c;
    logic [WIDTH-1:0]  b_eff_c;
    logic              c_eff_c;
    logic [STAGES:0]   vld_q;
    logic              c0_q;
    logic [STAGES:0]   carry_w;
    logic [WIDTH-1:0]  sum_w;

    // A stalled output freezes every rank; otherwise all ranks advance, bubbles included.
    assign stall_c      = vld_q[STAGES] & ~bus.out_ready;
    assign bus.in_ready = ~stall_c;
    assign b_eff_c      = bus.sub ? ~bus.in_b : bus.in_b;
    assign c_eff_c      = bus.sub | bus.cin;

    assign carry_w[0]    = c0_q;
    assign bus.out_valid = vld_q[STAGES];
    assign bus.sum       = sum_w;
    assign bus.cout      = carry_w[STAGES];

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            c0_q  <= 1'b0;
        end else if (!stall_c) begin
            vld_q <= {vld_q[STAGES-1:0], bus.in_valid};
            c0_q  <= c_eff_c;
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_slice
        // Operands wait s ranks for their carry; the result then waits to re-align.
        logic [SW-1:0] a_q [0:s];
        logic [SW-1:0] b_q [0:s];
        logic [SW-1:0] r_q [s+1:STAGES];
        logic          co_q;
        logic [SW-1:0] gen_c;
        logic [SW-1:0] prop_c;
        logic [NB:0]   blk_c;
        logic [SW:0]   cy_c;
        logic          grp_g;
        logic          grp_p;

        // Group generate/propagate per BLOCK, lookahead across groups, then bit carries.
        always_comb begin
            gen_c  = a_q[s] & b_q[s];
            prop_c = a_q[s] ^ b_q[s];
            blk_c  = '0;
            cy_c   = '0;
            grp_g  = 1'b0;
            grp_p  = 1'b1;
            blk_c[0] = carry_w[s];
            for (int k = 0; k < NB; k++) begin
                grp_g = 1'b0;
                grp_p = 1'b1;
                for (int i = 0; i < BLOCK; i++) begin
                    grp_g = gen_c[k*BLOCK+i] | (prop_c[k*BLOCK+i] & grp_g);
                    grp_p = grp_p & prop_c[k*BLOCK+i];
                end
                blk_c[k+1] = grp_g | (grp_p & blk_c[k]);
            end
            for (int k = 0; k < NB; k++) begin
                cy_c[k*BLOCK] = blk_c[k];
                for (int i = 1; i < BLOCK; i++) begin
                    cy_c[k*BLOCK+i] = gen_c[k*BLOCK+i-1] | (prop_c[k*BLOCK+i-1] & cy_c[k*BLOCK+i-1]);
                end
            end
            cy_c[SW] = blk_c[NB];
        end

        always_ff @(posedge CLK or negedge reset) begin
            if (!reset) begin
                for (int j = 0; j <= s; j++) begin
                    a_q[j] <= '0;
                    b_q[j] <= '0;
                end
                for (int j = s + 1; j <= STAGES; j++) begin
                    r_q[j] <= '0;
                end
                co_q <= 1'b0;
            end else if (!stall_c) begin
                a_q[0] <= bus.in_a[s*SW +: SW];
                b_q[0] <= b_eff_c[s*SW +: SW];
                for (int j = 1; j <= s; j++) begin
                    a_q[j] <= a_q[j-1];
                    b_q[j] <= b_q[j-1];
                end
                r_q[s+1] <= prop_c ^ cy_c[SW-1:0];
                for (int j = s + 2; j <= STAGES; j++) begin
                    r_q[j] <= r_q[j-1];
                end
                co_q <= cy_c[SW];
            end
        end

        assign carry_w[s+1]       = co_q;
        assign sum_w[s*SW +: SW]  = r_q[STAGES];

        // Signed overflow needs the carry into the MSB, which only the top slice sees.
        if (s == STAGES - 1) begin : g_msb
            logic ovf_q;

            always_ff @(posedge CLK or negedge reset) begin
                if (!reset) begin
                    ovf_q <= 1'b0;
                end else if (!stall_c) begin
                    ovf_q <= cy_c[SW] ^ cy_c[SW-1];
                end
            end

            assign bus.overflow = ovf_q;
        end
    end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed-vector and scoreboard bench for pipelined_cla_adder, including a
// streaming sweep over three other WIDTH/STAGES/BLOCK configurations.
module tb_pipelined_cla_adder;
    localparam int unsigned W   = 64;
    localparam int unsigned ST  = 4;
    localparam int unsigned NSW = 3;
    localparam int          SWN = 200;
    localparam int          NT  = 12;

    typedef struct packed {
        logic [127:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        int          t;
    } exp_t;

    function automatic int unsigned sw_width(input int i);
        case (i)
            0:       return 32;
            1:       return 64;
            default: return 128;
        endcase
    endfunction

    function automatic int unsigned sw_stages(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned sw_block(input int i);
        case (i)
            0:       return 4;
            1:       return 8;
            default: return 4;
        endcase
    endfunction

    // Reference: widen to w+1 bits; signed overflow from operand/result sign bits.
    function automatic res_t ref_calc(input int unsigned w, input logic [127:0] a,
                                      input logic [127:0] b, input logic cin, input logic sub);
        logic [128:0] m;
        logic [128:0] am;
        logic [128:0] bm;
        logic [128:0] r;
        res_t         o;
        m      = (129'(1) << w) - 129'(1);
        am     = {1'b0, a} & m;
        bm     = {1'b0, (sub ? ~b : b)} & m;
        r      = am + bm + 129'(sub | cin);
        o.sum  = r[127:0] & m[127:0];
        o.cout = r[w];
        o.ovf  = (am[w-1] == bm[w-1]) && (r[w-1] != am[w-1]);
        return o;
    endfunction

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_acc = 0;
    int   cyc   = 0;
    exp_t sbq[$];
    exp_t nox;
    vec_t tab [NT];

    logic         sw_valid;
    logic [127:0] sw_a;
    logic [127:0] sw_b;
    logic         sw_cin;
    logic         sw_sub;
    logic         sw_vld [NSW];
    logic         sw_rdy [NSW];
    logic [127:0] sw_sum [NSW];
    logic         sw_co  [NSW];
    logic         sw_ov  [NSW];

    always #5 clk = ~clk;

    pipelined_cla_adder_if #(.WIDTH(W)) bus ();
    pipelined_cla_adder #(.WIDTH(W), .STAGES(ST), .BLOCK(4)) dut (
        .CLK   (clk),
        .reset (reset),
        .bus   (bus)
    );

    for (genvar g = 0; g < NSW; g++) begin : g_sweep
        localparam int unsigned GW = sw_width(g);
        localparam int unsigned GS = sw_stages(g);
        localparam int unsigned GB = sw_block(g);

        pipelined_cla_adder_if #(.WIDTH(GW)) sbus ();
        pipelined_cla_adder #(.WIDTH(GW), .STAGES(GS), .BLOCK(GB)) sdut (
            .CLK   (clk),
            .reset (reset),
            .bus   (sbus)
        );

        assign sbus.in_valid  = sw_valid;
        assign sbus.in_a      = sw_a[GW-1:0];
        assign sbus.in_b      = sw_b[GW-1:0];
        assign sbus.cin       = sw_cin;
        assign sbus.sub       = sw_sub;
        assign sbus.out_ready = 1'b1;
        assign sw_vld[g]      = sbus.out_valid;
        assign sw_rdy[g]      = sbus.in_ready;
        assign sw_sum[g]      = 128'(sbus.sum);
        assign sw_co[g]       = sbus.cout;
        assign sw_ov[g]       = sbus.overflow;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    // One clock of the 64-bit DUT: drive, check handshake, hand off, record accept.
    task automatic step(input logic v, input logic [63:0] a, input logic [63:0] b,
                        input logic ci, input logic su, input logic rdy,
                        input logic use_ex, input exp_t ex, input logic chk_lat);
        exp_t        e;
        exp_t        h;
        res_t        r;
        logic        acc;
        logic        hs;
        logic        hold;
        logic [63:0] held_sum;
        logic        held_co;
        logic        held_ov;
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.cin       = ci;
        bus.sub       = su;
        bus.out_ready = rdy;
        #1;
        check("in_ready", 128'(bus.in_ready), 128'(!(bus.out_valid && !rdy)));
        if (sbq.size() == 0) check("idle_valid", 128'(bus.out_valid), 128'(0));
        acc  = v && bus.in_ready;
        hs   = bus.out_valid && rdy;
        hold = bus.out_valid && !rdy;
        if (hs && sbq.size() != 0) begin
            h = sbq.pop_front();
            check("sum", 128'(bus.sum), 128'(h.sum));
            check("cout", 128'(bus.cout), 128'(h.cout));
            check("overflow", 128'(bus.overflow), 128'(h.ovf));
            if (chk_lat) check("latency", 128'(cyc - h.t), 128'(ST + 1));
        end
        held_sum = bus.sum;
        held_co  = bus.cout;
        held_ov  = bus.overflow;
        @(posedge clk);
        if (acc) begin
            if (use_ex) begin
                e = ex;
            end else begin
                r      = ref_calc(W, 128'(a), 128'(b), ci, su);
                e.sum  = r.sum[63:0];
                e.cout = r.cout;
                e.ovf  = r.ovf;
            end
            e.t = cyc;
            sbq.push_back(e);
            n_acc++;
        end
        cyc++;
        #1;
        if (hold) begin
            check("stall_valid", 128'(bus.out_valid), 128'(1));
            check("stall_sum", 128'(bus.sum), 128'(held_sum));
            check("stall_cout", 128'(bus.cout), 128'(held_co));
            check("stall_ovf", 128'(bus.overflow), 128'(held_ov));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, nox, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0]  ra;
        logic [63:0]  rb;
        logic [127:0] sa  [SWN];
        logic [127:0] sbv [SWN];
        logic         sci [SWN];
        logic         ssu [SWN];
        exp_t         e;
        res_t         r;
        int           base;
        int           guard;
        int           j;
        logic         exp_v;

        tab[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
        tab[1]  = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        tab[2]  = '{64'h0, 64'h1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        tab[3]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        tab[4]  = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
        tab[5]  = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
                    64'h2222_2222_2222_2211, 1'b0, 1'b0};
        tab[6]  = '{64'h5, 64'h5, 1'b1, 1'b1, 64'h0, 1'b1, 1'b0};
        tab[7]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
        tab[8]  = '{64'h3, 64'h5, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        tab[9]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        tab[10] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0,
                    64'h0001_0000_0001_0000, 1'b0, 1'b0};
        tab[11] = '{64'h10, 64'h20, 1'b1, 1'b0, 64'h31, 1'b0, 1'b0};

        nox           = '{64'h0, 1'b0, 1'b0, 0};
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        sw_valid      = 1'b0;
        sw_a          = '0;
        sw_b          = '0;
        sw_cin        = 1'b0;
        sw_sub        = 1'b0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_sum", 128'(bus.sum), 128'(0));
        check("rst_cout", 128'(bus.cout), 128'(0));
        check("rst_overflow", 128'(bus.overflow), 128'(0));
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));
        reset = 1'b1;
        idle(10);

        // Directed table, one beat at a time with exact latency
        for (int i = 0; i < NT; i++) begin
            e.sum  = tab[i].sum;
            e.cout = tab[i].cout;
            e.ovf  = tab[i].ovf;
            e.t    = 0;
            step(1'b1, tab[i].a, tab[i].b, tab[i].cin, tab[i].sub, 1'b1, 1'b1, e, 1'b1);
            idle(ST + 1);
        end
        check("table_drain", 128'(sbq.size()), 128'(0));

        // Back-to-back streaming, no bubbles
        base = n_acc;
        for (int i = 0; i < SWN; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            step(1'b1, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, nox, 1'b1);
        end
        idle(ST + 2);
        check("stream_accepts", 128'(n_acc - base), 128'(SWN));
        check("stream_drain", 128'(sbq.size()), 128'(0));

        // Random backpressure
        base  = n_acc;
        guard = 0;
        while ((n_acc - base) < 500 && guard < 5000) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            step(1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, nox, 1'b0);
            guard++;
        end
        check("bp_accepts", 128'(n_acc - base), 128'(500));
        guard = 0;
        while (sbq.size() != 0 && guard < 50) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, nox, 1'b0);
            guard++;
        end
        check("bp_drain", 128'(sbq.size()), 128'(0));

        // Reset mid-operation discards in-flight beats
        for (int i = 0; i < 4; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            step(1'b1, ra, rb, 1'b0, 1'b0, 1'b1, 1'b0, nox, 1'b1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        cyc++;
        #1;
        check("pre_rst_valid", 128'(bus.out_valid), 128'(1));
        #2;
        reset = 1'b0;
        #1;
        check("midrst_valid", 128'(bus.out_valid), 128'(0));
        check("midrst_sum", 128'(bus.sum), 128'(0));
        check("midrst_in_ready", 128'(bus.in_ready), 128'(1));
        sbq.delete();
        #2;
        reset = 1'b1;
        idle(8);
        step(1'b1, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 1'b1, 1'b0, nox, 1'b1);
        idle(ST + 1);
        check("postrst_drain", 128'(sbq.size()), 128'(0));

        // Parameter sweep streaming; vector 0/1 exercise full carry and borrow chains
        for (int i = 0; i < SWN; i++) begin
            sa[i]  = {$urandom, $urandom, $urandom, $urandom};
            sbv[i] = {$urandom, $urandom, $urandom, $urandom};
            sci[i] = 1'($urandom_range(0, 1));
            ssu[i] = 1'($urandom_range(0, 1));
        end
        sa[0] = '1;  sbv[0] = '0; sci[0] = 1'b1; ssu[0] = 1'b0;
        sa[1] = '0;  sbv[1] = 128'(1); sci[1] = 1'b0; ssu[1] = 1'b1;
        for (int t = 0; t < SWN + 10; t++) begin
            sw_valid = (t < SWN);
            if (t < SWN) begin
                sw_a   = sa[t];
                sw_b   = sbv[t];
                sw_cin = sci[t];
                sw_sub = ssu[t];
            end
            @(posedge clk);
            cyc++;
            #1;
            for (int i = 0; i < int'(NSW); i++) begin
                j     = t - int'(sw_stages(i));
                exp_v = (j >= 0) && (j < SWN);
                check("sweep_valid", 128'(sw_vld[i]), 128'(exp_v));
                check("sweep_in_ready", 128'(sw_rdy[i]), 128'(1));
                if (exp_v) begin
                    r = ref_calc(sw_width(i), sa[j], sbv[j], sci[j], ssu[j]);
                    check("sweep_sum", sw_sum[i], r.sum);
                    check("sweep_cout", 128'(sw_co[i]), 128'(r.cout));
                    check("sweep_overflow", 128'(sw_ov[i]), 128'(r.ovf));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
